fifo_block_reader: RTL

//  Read side of the packet-holding byte FIFO: pops bytes and packs them into 128-bit AES blocks.

---
 rtl/aes_pkg.sv | 8 +
 rtl/flex_full_counter.sv | 35 +++
 rtl/fifo_block_reader.sv | 111 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types for the AES datapath front end: block geometry, reader FSM states, block word.
package aes_pkg;
  localparam int AES_BLOCK_BYTES = 16;

  typedef enum logic {FILL, HOLD} rd_state_t;

  typedef logic [127:0] aes_block_t;
endpackage

// File: rtl/flex_full_counter.sv
// Purpose: slot counter that counts on count_enable and wraps to 0 after rollover_val; clear wins.
// Latency: count_out updates on the edge after the enable; rollover_flag is registered alongside.
// Backpressure: none, the caller gates count_enable.
module flex_full_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);
  logic [NUM_CNT_BITS-1:0] count_n;

  always_comb begin
    count_n = count_out;
    if (clear) begin
      count_n = '0;
    end else if (count_enable) begin
      count_n = (count_out == rollover_val) ? '0 : count_out + NUM_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= count_n;
      rollover_flag <= (count_n == rollover_val);
    end
  end
endmodule

// File: rtl/fifo_block_reader.sv
// Purpose: pops FIFO bytes into 128-bit AES blocks; `FIFO_BLOCK_PAD_EN adds PKCS#7 flush padding.
// Latency: block_valid rises the cycle after the 16th pop (or after the pad cycle on a flush).
// Backpressure: holds the block and stops popping until block_valid && block_ready.
module fifo_block_reader
  import aes_pkg::*;
#(
  parameter int NUMBITS     = 8,
  parameter int BLOCK_BYTES = AES_BLOCK_BYTES,
  parameter int IDXCNT      = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           fifo_empty,
  input  logic [NUMBITS-1:0]             fifo_r_data,
  output logic                           fifo_r_enable,
  input  logic                           flush,
  output logic [NUMBITS*BLOCK_BYTES-1:0] block_data,
  output logic                           block_valid,
  input  logic                           block_ready,
  output logic                           block_last,
  output logic                           busy
);
  localparam int BW = NUMBITS * BLOCK_BYTES;
  localparam logic [IDXCNT-1:0] LAST_IDX = IDXCNT'(BLOCK_BYTES - 1);

  rd_state_t         state, state_n;
  logic [IDXCNT-1:0] idx;
  logic [BW-1:0]     block_q, block_n;
  logic              last_q, last_n;
  logic              pop, pad, flush_pend;
  logic [NUMBITS-1:0] pad_val;
  logic              unused_rollover;

  function automatic int slot_msb(input int slot);
    return BW - 1 - NUMBITS * slot;
  endfunction

  // Gating with n_rst keeps the FIFO from losing bytes while the reader is held in reset.
  assign pop     = n_rst && (state == FILL) && !fifo_empty;
  assign pad_val = NUMBITS'(BLOCK_BYTES - int'(idx));

`ifdef FIFO_BLOCK_PAD_EN
  assign pad = (state == FILL) && flush_pend && fifo_empty;

  // A flush landing on the pad cycle is merged into the block being closed.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) flush_pend <= 1'b0;
    else        flush_pend <= pad ? 1'b0 : (flush_pend | flush);
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign pad          = 1'b0;
  assign flush_pend   = 1'b0;
`endif

  flex_full_counter #(.NUM_CNT_BITS(IDXCNT)) u_slot_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (pad),
    .count_enable (pop),
    .rollover_val (LAST_IDX),
    .count_out    (idx),
    .rollover_flag(unused_rollover)
  );

  always_comb begin
    state_n = state;
    block_n = block_q;
    last_n  = last_q;
    case (state)
      FILL: begin
        if (pop) begin
          block_n[slot_msb(int'(idx)) -: NUMBITS] = fifo_r_data;
          if (idx == LAST_IDX) state_n = HOLD;
        end else if (pad) begin
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (i >= int'(idx)) block_n[slot_msb(i) -: NUMBITS] = pad_val;
          end
          state_n = HOLD;
          last_n  = 1'b1;
        end
      end
      HOLD: begin
        if (block_ready) begin
          state_n = FILL;
          last_n  = 1'b0;
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= FILL;
      block_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_n;
      block_q <= block_n;
      last_q  <= last_n;
    end
  end

  assign fifo_r_enable = pop;
  assign block_data    = block_q;
  assign block_valid   = (state == HOLD);
  assign block_last    = last_q;
  assign busy          = (idx != '0) || block_valid || flush_pend;
endmodule
